satatx_arb: RTL
===============

SATATX_ARB -- requirements
Module: satatx_arb

Interface
REQ-001 SHALL have parameter MAX_DWORDS, default 2048: maximum beats per FIS before forced truncation.
REQ-002 SHALL have parameter OPT_LOWPOWER, default 1: zero M_AXIS_TDATA/TLAST whenever M_AXIS_TVALID is low.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 i_clk  in  1  sole clock.
REQ-005 i_reset  in  1  synchronous active-high reset.
REQ-006 S0_AXIS_TVALID/TREADY/TDATA/TLAST  in/out/in/in  1/1/32/1  command-FIS source stream.
REQ-007 S1_AXIS_TVALID/TREADY/TDATA/TLAST  in/out/in/in  1/1/32/1  data-FIS source stream.
REQ-008 M_AXIS_TVALID/TREADY/TDATA/TLAST  out/in/out/out  1/1/32/1  merged stream into TX CRC stage.
REQ-009 o_grant  out  2  one-hot current owner: bit0 = S0, bit1 = S1, 0 = idle.
REQ-010 o_overflow  out  1  single-cycle pulse when a FIS is truncated at MAX_DWORDS.

Function
REQ-011 States SHALL be IDLE, GRANT, and DRAIN.
REQ-012 In IDLE with any source TVALID, the winner SHALL be latched and the state SHALL go to GRANT next cycle; no data beat SHALL be accepted in the IDLE cycle.
REQ-013 In GRANT, only the owner's TREADY SHALL be high, equal to (!M_AXIS_TVALID || M_AXIS_TREADY); the loser's TREADY SHALL be 0.
REQ-014 Each accepted owner beat SHALL appear on M_AXIS one cycle later (registered, latency 1), with TDATA and TLAST copied.
REQ-015 M_AXIS outputs SHALL hold stable while M_AXIS_TVALID && !M_AXIS_TREADY.
REQ-016 Acceptance of the owner's TLAST SHALL return the state to IDLE, and o_grant SHALL become 0 next cycle; back-to-back FIS SHALL therefore have at least a one-cycle gap in acceptance.
REQ-017 An 11-bit-min beat counter SHALL count accepted owner beats, clear on TLAST, and clear on leaving GRANT.
REQ-018 The beat numbered MAX_DWORDS without source TLAST SHALL be emitted with M_AXIS_TLAST = 1, pulse o_overflow for one cycle, and move the state to DRAIN.
REQ-019 In DRAIN, the owner's TREADY SHALL be 1 and beats SHALL be discarded (not forwarded) until the owner's TLAST is accepted, then the state SHALL go to IDLE.
REQ-020 A source TLAST arriving exactly on beat MAX_DWORDS SHALL be a normal end: no overflow and no DRAIN.
REQ-021 A non-owner source asserting TVALID mid-packet SHALL have no effect until the next IDLE.
REQ-022 Default arbitration (macro absent) SHALL be fixed priority, with S0 winning when both sources are valid.

Reset
REQ-023 i_reset SHALL set state IDLE, o_grant = 0, M_AXIS_TVALID = 0, M_AXIS_TLAST = 0, o_overflow = 0, and counter = 0; M_AXIS_TDATA SHALL be 0 when OPT_LOWPOWER is set.
REQ-024 Reset mid-packet SHALL abandon the packet with no TLAST emitted; downstream relies on the same reset.
REQ-025 Both source TREADY outputs SHALL be 0 during reset.

Configuration
REQ-026 With SATATX_ARB_RR_EN defined, arbitration SHALL be round-robin: on simultaneous requests, the source not granted last SHALL win, and a last-winner register SHALL reset to S1 so that S0 wins first.
REQ-027 Without SATATX_ARB_RR_EN, arbitration SHALL follow REQ-022 and no last-winner register SHALL exist.

Structure
REQ-028 Shared package satatx_pkg SHALL hold the state encoding enum and the MAX_FIS_DWORDS = 2048 constant.
REQ-029 Grant selection SHALL be one combinational sub-module, satatx_arb_pick (requests and last winner in, one-hot grant out); all else SHALL be inline.

Verification
REQ-030 S0 sends a 3-beat FIS 0x11,0x22,0x33 with M ready -> the M stream carries the same 3 beats, TLAST on 0x33, first beat 2 cycles after S0_TVALID, o_grant = 01 throughout.
REQ-031 S0 and S1 both valid continuously with 2-beat FIS each -> fixed mode: all S0 FIS sent, S1 starved; with SATATX_ARB_RR_EN: grants alternate 01,10,01,10.
REQ-032 S1 sends a 5-beat FIS while M_AXIS_TREADY toggles 1,0,0,1 repeating -> M data/last stable while stalled, all 5 beats delivered in order, S0 TREADY = 0 throughout.
REQ-033 MAX_DWORDS = 4, S0 sends 6 beats (TLAST on 6) -> M delivers 4 beats with TLAST on beat 4, o_overflow pulses once, beats 5–6 are consumed and dropped, then IDLE.
REQ-034 MAX_DWORDS = 4, S0 sends exactly 4 beats with TLAST -> normal completion, o_overflow stays 0.
REQ-035 i_reset asserted after beat 2 of a 5-beat S1 FIS -> the next cycle shows M_AXIS_TVALID = 0 and o_grant = 0, and a new S0 FIS after reset completes normally.

Source files
------------

// File: rtl/satatx_arb_pkg.sv
// satatx_arb_pkg: arbiter state encoding and FIS length limit shared by the SATA TX arbiter files
package satatx_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_DRAIN} state_t;
   localparam int MAX_FIS_DWORDS = 2048;
endpackage

// File: rtl/satatx_arb_pick.sv
// satatx_arb_pick: one-hot grant from two requests; round-robin when SATATX_ARB_RR_EN is defined
module satatx_arb_pick (
   input  logic [1:0] req,
   input  logic [1:0] last,
   output logic [1:0] grant
);
`ifdef SATATX_ARB_RR_EN
   assign grant = (&req) ? (last[0] ? 2'b10 : 2'b01) : req;
`else
   logic unused_last;
   assign unused_last = ^last;
   assign grant = req[0] ? 2'b01 : {req[1], 1'b0};
`endif
endmodule

// File: rtl/satatx_arb.sv
// satatx_arb: merges command (S0) and data (S1) FIS streams into the TX CRC stage with MAX_DWORDS truncation
// Define SATATX_ARB_RR_EN for round-robin arbitration instead of fixed S0 priority.
module satatx_arb
   import satatx_pkg::*;
#(
   parameter int MAX_DWORDS   = MAX_FIS_DWORDS,
   parameter bit OPT_LOWPOWER = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        S0_AXIS_TVALID,
   output logic        S0_AXIS_TREADY,
   input  logic [31:0] S0_AXIS_TDATA,
   input  logic        S0_AXIS_TLAST,
   input  logic        S1_AXIS_TVALID,
   output logic        S1_AXIS_TREADY,
   input  logic [31:0] S1_AXIS_TDATA,
   input  logic        S1_AXIS_TLAST,
   output logic        M_AXIS_TVALID,
   input  logic        M_AXIS_TREADY,
   output logic [31:0] M_AXIS_TDATA,
   output logic        M_AXIS_TLAST,
   output logic [1:0]  o_grant,
   output logic        o_overflow
);
   localparam int CW = ($clog2(MAX_DWORDS + 1) > 11) ? $clog2(MAX_DWORDS + 1) : 11;
   localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_DWORDS - 1);
   state_t        state;
   logic [CW-1:0] cnt;
   logic [1:0]    req, pick, last_win;
   logic [31:0]   s_data;
   logic          s_valid, s_last, s_ready, accept, m_free, trunc;
   assign req = {S1_AXIS_TVALID, S0_AXIS_TVALID};
`ifdef SATATX_ARB_RR_EN
   always_ff @(posedge i_clk)
      if (i_reset)
         last_win <= 2'b10;
      else if (state == ST_IDLE && |req)
         last_win <= pick;
`else
   assign last_win = 2'b10;
`endif
   satatx_arb_pick u_pick (.req(req), .last(last_win), .grant(pick));
   assign m_free  = !M_AXIS_TVALID || M_AXIS_TREADY;
   assign s_ready = !i_reset && ((state == ST_GRANT && m_free) || state == ST_DRAIN);
   assign S0_AXIS_TREADY = s_ready && o_grant[0];
   assign S1_AXIS_TREADY = s_ready && o_grant[1];
   assign s_valid = o_grant[1] ? S1_AXIS_TVALID : S0_AXIS_TVALID;
   assign s_data  = o_grant[1] ? S1_AXIS_TDATA  : S0_AXIS_TDATA;
   assign s_last  = o_grant[1] ? S1_AXIS_TLAST  : S0_AXIS_TLAST;
   assign accept  = s_valid && s_ready;
   // a source TLAST on the limit beat is a normal end, so truncation needs it absent
   assign trunc   = cnt == LAST_BEAT && !s_last;
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state         <= ST_IDLE;
         o_grant       <= 2'b00;
         cnt           <= '0;
         o_overflow    <= 1'b0;
         M_AXIS_TVALID <= 1'b0;
         M_AXIS_TDATA  <= 32'h0;
         M_AXIS_TLAST  <= 1'b0;
      end else begin
         o_overflow <= 1'b0;
         if (m_free && !(accept && state == ST_GRANT)) begin
            M_AXIS_TVALID <= 1'b0;
            if (OPT_LOWPOWER) begin
               M_AXIS_TDATA <= 32'h0;
               M_AXIS_TLAST <= 1'b0;
            end
         end
         case (state)
            ST_IDLE:
               if (|req) begin
                  o_grant <= pick;
                  state   <= ST_GRANT;
               end
            ST_GRANT:
               if (accept) begin
                  M_AXIS_TVALID <= 1'b1;
                  M_AXIS_TDATA  <= s_data;
                  M_AXIS_TLAST  <= s_last || trunc;
                  cnt           <= (s_last || trunc) ? '0 : cnt + 1'b1;
                  if (s_last) begin
                     state   <= ST_IDLE;
                     o_grant <= 2'b00;
                  end else if (trunc) begin
                     state      <= ST_DRAIN;
                     o_overflow <= 1'b1;
                  end
               end
            ST_DRAIN:
               if (accept && s_last) begin
                  state   <= ST_IDLE;
                  o_grant <= 2'b00;
               end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
